// File: rtl/instmem_loadable_if.sv
// Fetch and loader bus for instmem_loadable. The master side is the IF stage
// plus the download path, and the slave side is the memory.
interface instmem_loadable_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  stall;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  ld_start;
  logic [ADDR_WIDTH-1:0] ld_base;
  logic [ADDR_WIDTH:0]   ld_count;
  logic                  ld_byte_valid;
  logic [7:0]            ld_byte;
  logic                  ld_byte_ready;
  logic                  ld_busy;
  logic                  ld_done;
  logic [ADDR_WIDTH:0]   ld_words;

  modport master (
    output fetch_en, fetch_addr, stall, ld_start, ld_base, ld_count, ld_byte_valid, ld_byte,
    input  dout, dout_valid, ld_byte_ready, ld_busy, ld_done, ld_words
  );
  modport slave (
    input  fetch_en, fetch_addr, stall, ld_start, ld_base, ld_count, ld_byte_valid, ld_byte,
    output dout, dout_valid, ld_byte_ready, ld_busy, ld_done, ld_words
  );
endinterface

// File: rtl/instmem_loadable.sv
// Synchronous-read instruction memory with a registered fetch port and a
// byte-serial loader that assembles words and writes them at run time.
module instmem_loadable #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 512,
  parameter int BIG_ENDIAN = 1
) (
  input logic              clk,
  input logic              rst,
  instmem_loadable_if.slave bus
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_WIDTH:0] LP_SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  // Array is deliberately left out of reset so a loaded program survives rst.
  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_words;
  logic [BCW-1:0]        r_bcnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_busy;
  logic                  r_rdy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dvld;

  logic                  w_take;
  logic                  w_last;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [ADDR_WIDTH:0]   w_words_nx;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_take     = bus.ld_byte_valid & r_rdy;
  assign w_last     = (r_bcnt == BCW'(BPW-1));
  assign w_waddr    = r_base + r_words[ADDR_WIDTH-1:0];
  assign w_words_nx = r_words + (ADDR_WIDTH+1)'(1);
  assign w_we       = w_take & w_last & ({1'b0, w_waddr} < LP_SIZE);

  // Merge the incoming byte into its lane so the final byte can be written
  // together with the rest of the word on the same edge.
  always_comb begin
    w_word = r_word;
    for (int k = 0; k < BPW; k++) begin
      if (r_bcnt == BCW'(k)) begin
        if (BIG_ENDIAN != 0) w_word[DATA_WIDTH-8-8*k +: 8] = bus.ld_byte;
        else                 w_word[8*k +: 8]              = bus.ld_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
      r_dvld <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.fetch_en && !r_busy) begin
        r_dvld <= 1'b1;
        r_dout <= ({1'b0, bus.fetch_addr} < LP_SIZE) ? r_mem[bus.fetch_addr] : '0;
      end else begin
        r_dvld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_count <= '0;
      r_words <= '0;
      r_bcnt  <= '0;
      r_word  <= '0;
      r_busy  <= 1'b0;
      r_rdy   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.ld_start) begin
            r_words <= '0;
            r_bcnt  <= '0;
            if (bus.ld_count != '0) begin
              r_state <= S_LOAD;
              r_base  <= bus.ld_base;
              r_count <= bus.ld_count;
              r_busy  <= 1'b1;
              r_rdy   <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_take) begin
            if (w_last) begin
              r_words <= w_words_nx;
              r_bcnt  <= '0;
              if (w_words_nx == r_count) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_rdy   <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_word <= w_word;
              r_bcnt <= r_bcnt + BCW'(1);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dout          = r_dout;
  assign bus.dout_valid    = r_dvld;
  assign bus.ld_byte_ready = r_rdy;
  assign bus.ld_busy       = r_busy;
  assign bus.ld_done       = r_done;
  assign bus.ld_words      = r_words;
endmodule

// File: tb/tb_instmem_loadable.sv
// Drives three instances (big-endian 512, little-endian 512, big-endian 500)
// with one stimulus stream and checks each against a word-level memory model.
module tb_instmem_loadable;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          fetch_en = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          stall = 1'b0;
  logic          ld_start = 1'b0;
  logic [AW-1:0] ld_base = '0;
  logic [AW:0]   ld_count = '0;
  logic          ld_byte_valid = 1'b0;
  logic [7:0]    ld_byte = '0;

  instmem_loadable_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifs [NI] ();

  logic [DW-1:0] o_dout [NI];
  logic          o_vld  [NI];
  logic          o_rdy  [NI];
  logic          o_busy [NI];
  logic          o_done [NI];
  logic [AW:0]   o_words[NI];

  for (genvar g = 0; g < NI; g++) begin : g_bus
    assign ifs[g].fetch_en      = fetch_en;
    assign ifs[g].fetch_addr    = fetch_addr;
    assign ifs[g].stall         = stall;
    assign ifs[g].ld_start      = ld_start;
    assign ifs[g].ld_base       = ld_base;
    assign ifs[g].ld_count      = ld_count;
    assign ifs[g].ld_byte_valid = ld_byte_valid;
    assign ifs[g].ld_byte       = ld_byte;
    assign o_dout[g]  = ifs[g].dout;
    assign o_vld[g]   = ifs[g].dout_valid;
    assign o_rdy[g]   = ifs[g].ld_byte_ready;
    assign o_busy[g]  = ifs[g].ld_busy;
    assign o_done[g]  = ifs[g].ld_done;
    assign o_words[g] = ifs[g].ld_words;
  end

  instmem_loadable #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(512), .BIG_ENDIAN(1))
    u_be (.clk(clk), .rst(rst), .bus(ifs[0]));
  instmem_loadable #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(512), .BIG_ENDIAN(0))
    u_le (.clk(clk), .rst(rst), .bus(ifs[1]));
  instmem_loadable #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(500), .BIG_ENDIAN(1))
    u_ms (.clk(clk), .rst(rst), .bus(ifs[2]));

  // Reference model
  int            msz [NI] = '{512, 512, 500};
  bit            mbe [NI] = '{1'b1, 1'b0, 1'b1};
  logic [DW-1:0] m_mem [NI][512];
  logic [DW-1:0] e_dout [NI];
  logic          e_vld  [NI];
  bit            m_busy;
  logic [7:0]    q_bytes [$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ld(input string tag, input bit d, input bit b, input bit r, input int w);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s.done[%0d]", tag, i), o_done[i], d);
      chk($sformatf("%s.busy[%0d]", tag, i), o_busy[i], b);
      chk($sformatf("%s.rdy[%0d]", tag, i), o_rdy[i], r);
      chk($sformatf("%s.words[%0d]", tag, i), o_words[i], w);
    end
  endtask

  // Advance one cycle: predict the fetch port from the current inputs, then
  // compare every instance just after the edge.
  task automatic cyc();
    for (int i = 0; i < NI; i++) begin
      if (!stall) begin
        if (fetch_en && !m_busy) begin
          e_vld[i]  = 1'b1;
          e_dout[i] = (int'(fetch_addr) < msz[i]) ? m_mem[i][fetch_addr] : '0;
        end else begin
          e_vld[i] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("dout[%0d]", i), o_dout[i], e_dout[i]);
      chk($sformatf("vld[%0d]", i), o_vld[i], e_vld[i]);
    end
  endtask

  task automatic commit(input int base, input int w, input logic [31:0] wbe);
    int a;
    a = (base + w) % 512;
    for (int i = 0; i < NI; i++)
      if (a < msz[i])
        m_mem[i][a] = mbe[i] ? wbe : {wbe[7:0], wbe[15:8], wbe[23:16], wbe[31:24]};
  endtask

  task automatic hit_reset(input string tag);
    rst = 1'b1;
    #1;
    fetch_en = 0; stall = 0; ld_start = 0; ld_byte_valid = 0;
    m_busy = 0;
    for (int i = 0; i < NI; i++) begin
      e_dout[i] = '0; e_vld[i] = 1'b0;
      chk($sformatf("%s.dout[%0d]", tag, i), o_dout[i], 0);
      chk($sformatf("%s.vld[%0d]", tag, i), o_vld[i], 0);
    end
    chk_ld(tag, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Sends nbytes bytes of a cnt-word session; nbytes < 4*cnt leaves it mid-load.
  task automatic do_load(input int base, input int cnt, input int nbytes);
    logic [7:0] b [4];
    ld_base = AW'(base); ld_count = (AW+1)'(cnt); ld_start = 1'b1;
    fetch_en = 0; stall = 0;
    ld_byte_valid = 1'b1; ld_byte = 8'hEE;
    cyc();
    ld_start = 1'b0; ld_byte_valid = 1'b0;
    if (cnt == 0) begin
      chk_ld("zero", 1, 0, 0, 0);
      cyc();
      chk_ld("zero_after", 0, 0, 0, 0);
      return;
    end
    m_busy = 1;
    chk_ld("start", 0, 1, 1, 0);
    for (int k = 0; k < nbytes; k++) begin
      while ($urandom_range(3) == 0) begin
        ld_byte_valid = 1'b0;
        fetch_en = 1'($urandom); fetch_addr = AW'($urandom);
        cyc();
      end
      ld_byte_valid = 1'b1;
      ld_byte = (q_bytes.size() > 0) ? q_bytes.pop_front() : 8'($urandom);
      b[k%4] = ld_byte;
      fetch_en = 1'($urandom); fetch_addr = AW'($urandom);
      cyc();
      if (k % 4 == 3) begin
        commit(base, k / 4, {b[0], b[1], b[2], b[3]});
        if (k / 4 + 1 == cnt) m_busy = 0;
        else chk_ld("word", 0, 1, 1, k / 4 + 1);
      end
    end
    ld_byte_valid = 1'b0; fetch_en = 1'b0;
    if (nbytes == 4 * cnt) begin
      chk_ld("done", 1, 0, 0, cnt);
      // Fetch in the DONE cycle must see the word just written.
      fetch_en = 1'b1; fetch_addr = AW'((base + cnt - 1) % 512);
      ld_byte_valid = 1'b1; ld_byte = 8'h5A;
      cyc();
      fetch_en = 1'b0; ld_byte_valid = 1'b0;
      chk_ld("idle", 0, 0, 0, cnt);
    end
  endtask

  task automatic fetch_one(input int a);
    fetch_en = 1'b1; fetch_addr = AW'(a); stall = 1'b0;
    cyc();
    fetch_en = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] old11;
    m_busy = 0;
    @(posedge clk); #1;
    hit_reset("reset");

    do_load(0, 512, 2048);

    q_bytes = '{8'h3c, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3a, 8'h00, 8'h00};
    do_load(0, 2, 8);
    fetch_one(0);
    chk("tp_w0", o_dout[0], 32'h3c011001);
    fetch_one(1);
    chk("tp_w1", o_dout[0], 32'h343a0000);

    q_bytes = '{8'h01, 8'h10, 8'h01, 8'h3c};
    do_load(5, 1, 4);
    fetch_one(5);
    chk("tp_le5", o_dout[1], 32'h3c011001);

    fetch_one(0);
    stall = 1'b1; fetch_en = 1'b1; fetch_addr = AW'(1);
    repeat (3) begin
      cyc();
      chk("tp_stall_dout", o_dout[0], 32'h3c011001);
      chk("tp_stall_vld", o_vld[0], 1);
    end
    stall = 1'b0;
    cyc();
    fetch_en = 1'b0;
    chk("tp_unstall", o_dout[0], 32'h343a0000);

    do_load(511, 2, 8);
    fetch_one(511);
    fetch_one(0);
    do_load(499, 2, 8);
    fetch_one(499);
    fetch_one(500);
    chk("tp_oob_dout", o_dout[2], 0);
    chk("tp_oob_vld", o_vld[2], 1);

    do_load(0, 0, 0);

    for (int n = 0; n < 6; n++) begin
      int cnt;
      cnt = $urandom_range(8, 1);
      do_load($urandom_range(511), cnt, 4 * cnt);
    end

    for (int n = 0; n < 300; n++) begin
      stall = ($urandom_range(3) == 0);
      fetch_en = ($urandom_range(3) != 0);
      fetch_addr = AW'($urandom);
      cyc();
    end
    stall = 1'b0; fetch_en = 1'b0;

    old11 = m_mem[0][11];
    do_load(10, 2, 6);
    hit_reset("abort");
    fetch_one(10);
    fetch_one(11);
    chk("abort_w11", o_dout[0], old11);
    do_load(10, 2, 8);
    fetch_one(10);
    fetch_one(11);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/instmem_loadable.md
Name: instmem_loadable

Overview:
Parametrised successor to the core's combinational instruction ROM. It is a synchronous-read instruction memory with a registered fetch port and fetch stall/hold. A byte-serial program loader assembles words and writes them into the array at run time, so programs load without re-synthesis. It sits between the IF stage (fetch port) and the debug/UART download path (loader port).

Parameters:
ADDR_WIDTH, 9, word-address width
DATA_WIDTH, 32, instruction width; must be a multiple of 8; BPW = DATA_WIDTH/8 bytes per word
MEM_SIZE, 512, number of words; must satisfy 1 <= MEM_SIZE <= 2^ADDR_WIDTH
BIG_ENDIAN, 1, 1 = first loaded byte goes to the MSB; 0 = first loaded byte goes to the LSB

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
fetch_en  in  1  fetch request
fetch_addr  in  ADDR_WIDTH  word address to fetch
stall  in  1  hold the fetch output
dout  out  DATA_WIDTH  fetched instruction, registered
dout_valid  out  1  dout holds data for the last accepted fetch
ld_start  in  1  start a load session
ld_base  in  ADDR_WIDTH  first word address of the load
ld_count  in  ADDR_WIDTH+1  number of words to load
ld_byte_valid  in  1  loader byte strobe
ld_byte  in  8  loader data byte
ld_byte_ready  out  1  loader accepts a byte this cycle
ld_busy  out  1  load session active
ld_done  out  1  one-cycle pulse at the end of a session
ld_words  out  ADDR_WIDTH+1  words written in the current or last session

Behaviour:
- Reset (rst asynchronous, active-high; clock is clk): dout=0, dout_valid=0, ld_byte_ready=0, ld_busy=0, ld_done=0, ld_words=0, FSM=IDLE, byte counter=0.
- The memory array is not reset. Contents survive rst.
- Fetch is accepted when fetch_en & !stall & !ld_busy.
  - On accept: next edge dout <= RAM[fetch_addr] and dout_valid <= 1. Latency is 1 cycle.
  - If fetch_addr >= MEM_SIZE: dout <= 0 and dout_valid <= 1.
- stall=1: dout and dout_valid hold, regardless of fetch_en. stall has priority over everything except rst.
- !stall and not accepted (fetch_en=0 or ld_busy=1): dout_valid <= 0 and dout holds its value.
- FSM IDLE:
  - ld_start=1 and ld_count != 0 -> LOAD. Latch base and count, set ld_words=0, byte counter=0.
  - ld_start=1 and ld_count == 0 -> stay IDLE, ld_done=1 for one cycle, ld_words=0.
- FSM LOAD:
  - ld_busy=1 and ld_byte_ready=1.
  - A byte is taken on ld_byte_valid & ld_byte_ready and placed at lane k (k = byte counter).
  - BIG_ENDIAN=1: lane k maps to bits [DATA_WIDTH-1-8k -: 8]. BIG_ENDIAN=0: lane k maps to bits [8k +: 8].
  - On the BPW-th byte, the word is written at the edge that accepts that byte.
  - Write address = (base + ld_words) mod 2^ADDR_WIDTH. A write to an address >= MEM_SIZE is dropped but still counted.
  - After each write, ld_words increments and the byte counter returns to 0.
  - When ld_words reaches the latched count -> DONE.
  - ld_start while in LOAD is ignored.
- FSM DONE: ld_done=1, ld_busy=0, ld_byte_ready=0 for exactly one cycle -> IDLE. ld_words holds until the next ld_start.
- Fetch is blocked during LOAD, so reads and writes never collide.
  - A fetch request arriving in the cycle of the DONE pulse is accepted.
  - That fetch returns newly written data.
- rst during LOAD:
  - The session aborts and the partial word is discarded.
  - Words already written remain.
  - All outputs return to reset values.
- Bytes presented while ld_byte_ready=0 are not consumed and must be ignored.

Test Plan:
- Load ld_base=0, ld_count=2, bytes 3C 01 10 01 34 3A 00 00 (BIG_ENDIAN=1) -> ld_done pulses once, ld_words=2. Fetch addr 0 then 1 -> dout=32'h3c011001, then 32'h343a0000, each valid 1 cycle after request.
- BIG_ENDIAN=0, load 1 word at addr 5 with bytes 01 10 01 3C -> fetch 5 gives 32'h3c011001.
- Fetch addr 0 with dout_valid=1, then stall=1 for 3 cycles while fetch_addr=1 -> dout stays 32'h3c011001 and valid=1. Release stall -> next cycle dout=32'h343a0000.
- ld_base=511, ld_count=2 (MEM_SIZE=512) -> words land at 511 and 0 (wrap). With MEM_SIZE=500 and base=499: the word at 499 is written, the word at 500 is dropped, ld_words=2, and a fetch of 500 returns 0 with valid=1.
- ld_count=0 -> ld_done high for 1 cycle, ld_busy never asserts. Fetch during an active load -> dout_valid=0.
- Assert rst after 6 bytes of a 2-word load -> all outputs 0. Word 0 holds new data. Word 1 is unchanged. A subsequent ld_start is accepted normally.
